// File: rtl/shift_add_multiplier_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
// The master drives start/abort and operands; the slave (the multiplier)
// returns busy/done status and the registered product with its flags.
interface shift_add_multiplier_if #(
    parameter int SIZE = 64
);
    logic                  i_start;
    logic                  i_abort;
    logic [SIZE-1:0]       i_A;
    logic [SIZE-1:0]       i_B;
    logic                  o_busy;
    logic                  o_done;
    logic [2*SIZE-1:0]     o_product;
    logic                  o_msb;
    logic                  o_zero;

    modport master (
        output i_start,
        output i_abort,
        output i_A,
        output i_B,
        input  o_busy,
        input  o_done,
        input  o_product,
        input  o_msb,
        input  o_zero
    );

    modport slave (
        input  i_start,
        input  i_abort,
        input  i_A,
        input  i_B,
        output o_busy,
        output o_done,
        output o_product,
        output o_msb,
        output o_zero
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add mantissa multiplier.
// One multiplier bit is consumed per clock in RUN; the 2*SIZE-bit product is
// registered on entry to DONE, which lasts one cycle and raises o_done.
// Optional build macro SHIFT_ADD_MULT_EARLY_TERM_EN: leave RUN as soon as the
// unprocessed multiplier bits are all zero and apply the outstanding right
// shift in a single step when loading the product (result is unchanged).
module shift_add_multiplier #(
    parameter int SIZE = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    shift_add_multiplier_if.slave  bus
);

    localparam int CW = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE-1:0]     a_q, a_d;
    logic [SIZE-1:0]     hi_q, hi_d;
    logic [SIZE-1:0]     lo_q, lo_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*SIZE-1:0]   product_q, product_d;

    // The carry of the working register lives in the top bit of sum; after
    // the right shift it lands in hi and the stored carry is always zero,
    // so it needs no flop of its own.
    logic [SIZE:0]       sum;
    logic [SIZE-1:0]     hi_shift;
    logic [SIZE-1:0]     lo_shift;
    logic                last_iter;
    logic [2*SIZE-1:0]   done_product;

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    // Copy of the multiplier bits not yet consumed; lets the exit test look
    // at the remaining bits without masking the mixed product/multiplier lo.
    logic [SIZE-1:0]     b_rem_q, b_rem_d;
    logic [CW-1:0]       shamt;
`endif

    // One shift-and-add step plus the RUN exit condition and DONE load value
    always_comb begin
        sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(SIZE+1){1'b0}});
        hi_shift = sum[SIZE:1];
        lo_shift = {sum[0], lo_q[SIZE-1:1]};
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        // Remaining multiplier bits after this iteration are b_rem_q >> 1;
        // the product still needs SIZE-1-cnt more right shifts.
        last_iter    = (b_rem_q[SIZE-1:1] == '0);
        shamt        = CW'(SIZE - 1) - cnt_q;
        done_product = {hi_shift, lo_shift} >> shamt;
`else
        last_iter    = (cnt_q == CW'(SIZE - 1));
        done_product = {hi_shift, lo_shift};
`endif
    end

    // Next-state and datapath register loads; abort always wins over start
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        b_rem_d   = b_rem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                end else if (bus.i_start) begin
                    state_d = RUN;
                    a_d     = bus.i_A;
                    hi_d    = '0;
                    lo_d    = bus.i_B;
                    cnt_d   = '0;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                    b_rem_d = bus.i_B;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.i_abort) begin
                    // Operation dropped; the last completed product stays
                    state_d = IDLE;
                end else begin
                    hi_d  = hi_shift;
                    lo_d  = lo_shift;
                    cnt_d = cnt_q + CW'(1);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                    b_rem_d = b_rem_q >> 1;
`endif
                    if (last_iter) begin
                        state_d   = DONE;
                        product_d = done_product;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
            b_rem_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
            b_rem_q   <= b_rem_d;
`endif
        end
    end

    assign bus.o_busy    = (state_q == RUN);
    assign bus.o_done    = (state_q == DONE);
    assign bus.o_product = product_q;
    assign bus.o_msb     = product_q[2*SIZE-1];
    assign bus.o_zero    = (product_q == '0);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier at SIZE=8 with directed vectors.
module tb_shift_add_multiplier;

    localparam int SIZE = 8;

    typedef struct {
        logic [2*SIZE-1:0] prod;
        int                cyc;
    } exp_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_pass  = 0;
    int   done_seen = 0;
    exp_t sb_q[$];

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    shift_add_multiplier_if #(.SIZE(SIZE)) bus ();

    shift_add_multiplier #(.SIZE(SIZE)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Cycles from accepting edge to the o_done cycle
    function automatic int lat(input logic [SIZE-1:0] b);
        int runs;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
        runs = 1;
        for (int i = 0; i < SIZE; i++) if (b[i]) runs = i + 1;
`else
        runs = SIZE;
        if (b == 0) runs = SIZE;
`endif
        return runs + 1;
    endfunction

    // Called at a negedge: start is taken at the next edge; returns in RUN cycle 1
    task automatic issue(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                         input logic [2*SIZE-1:0] p, input bit push);
        exp_t e;
        bus.i_A     = a;
        bus.i_B     = b;
        bus.i_start = 1'b1;
        e.prod = p;
        e.cyc  = cyc + lat(b);
        if (push) sb_q.push_back(e);
        $display("issue A=0x%02h B=0x%02h expect=0x%04h scored=%0d", a, b, p, push);
        @(negedge i_clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!bus.o_done && k < budget) begin
            @(negedge i_clk);
            k++;
        end
        if (!bus.o_done) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: every o_done pops one expected product and compares it
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst_n && bus.o_done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                $display("done product=0x%04h expect=0x%04h cycle=%0d", bus.o_product, e.prod, cyc);
                check("product", 32'(bus.o_product), 32'(e.prod));
                check("msb", 32'(bus.o_msb), 32'(e.prod[2*SIZE-1]));
                check("zero", 32'(bus.o_zero), 32'(e.prod == 0));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    typedef struct {
        logic [SIZE-1:0]   a;
        logic [SIZE-1:0]   b;
        logic [2*SIZE-1:0] p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int seen;
        int d1;
        int d2;
        vecs[0] = '{8'h00, 8'hA5, 16'h0000};
        vecs[1] = '{8'h12, 8'h03, 16'h0036};
        vecs[2] = '{8'h12, 8'h00, 16'h0000};
        vecs[3] = '{8'h80, 8'h02, 16'h0100};
        vecs[4] = '{8'h01, 8'h80, 16'h0080};
        vecs[5] = '{8'hAB, 8'hCD, 16'h88EF};

        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_A     = '0;
        bus.i_B     = '0;
        repeat (2) @(negedge i_clk);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_product", 32'(bus.o_product), 32'd0);
        check("rst_msb", 32'(bus.o_msb), 32'd0);
        check("rst_zero", 32'(bus.o_zero), 32'd1);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // 0xFF*0xFF with busy window cycles 1..8 and done in cycle 9
        issue(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        for (int k = 1; k <= SIZE; k++) begin
            check("busy_run", 32'(bus.o_busy), 32'd1);
            check("no_early_done", 32'(bus.o_done), 32'd0);
            @(negedge i_clk);
        end
        check("busy_after", 32'(bus.o_busy), 32'd0);
        check("done_cycle9", 32'(bus.o_done), 32'd1);

        // Directed vectors, each started in the previous DONE cycle
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
            wait_done(3 * SIZE);
        end

        // Abort in RUN cycle 4: no done, product keeps 0x88EF
        @(negedge i_clk);
        seen = done_seen;
        issue(8'h10, 8'h10, 16'h0100, 1'b0);
        repeat (3) @(negedge i_clk);
        bus.i_abort = 1'b1;
        @(negedge i_clk);
        bus.i_abort = 1'b0;
        check("abort_busy", 32'(bus.o_busy), 32'd0);
        check("abort_keep_product", 32'(bus.o_product), 32'h88EF);
        repeat (2 * SIZE) @(negedge i_clk);
        check("abort_no_done", done_seen, seen);

        // Abort in IDLE suppresses a same-cycle start
        bus.i_A = 8'h05; bus.i_B = 8'h05;
        bus.i_start = 1'b1; bus.i_abort = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0; bus.i_abort = 1'b0;
        check("abort_idle_start", 32'(bus.o_busy), 32'd0);

        issue(8'h03, 8'h05, 16'h000F, 1'b1);
        wait_done(3 * SIZE);

        // Reset asserted in RUN cycle 5
        @(negedge i_clk);
        seen = done_seen;
        issue(8'hFF, 8'h81, 16'h807F, 1'b0);
        repeat (4) @(negedge i_clk);
        check("pre_rst_busy", 32'(bus.o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_done", 32'(bus.o_done), 32'd0);
        check("mid_rst_product", 32'(bus.o_product), 32'd0);
        check("mid_rst_msb", 32'(bus.o_msb), 32'd0);
        check("mid_rst_zero", 32'(bus.o_zero), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2 * SIZE) @(negedge i_clk);
        check("rst_no_done", done_seen, seen);

        // Back-to-back: second start during the first DONE cycle
        issue(8'hFF, 8'hFF, 16'hFE01, 1'b1);
        wait_done(3 * SIZE);
        d1 = cyc;
        issue(8'hAB, 8'hCD, 16'h88EF, 1'b1);
        wait_done(3 * SIZE);
        d2 = cyc;
        check("b2b_spacing", d2 - d1, SIZE + 1);

        repeat (3) @(negedge i_clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
